mu_host_read_dma: RTL

Host read DMA engine for the matmul AFU. It sits directly upstream of the system wrapper's `host_read_*` Avalon-MM requestor port. From a start command it fetches a contiguous block of 64-byte lines from host memory using naturally aligned bursts of 1, 2 or 4 lines. Returned lines are buffered in a credit-protected FIFO and delivered to the matmul unit on a valid/ready stream.

---
 rtl/mu_host_read_dma.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mu_host_read_dma.sv
// mu_host_read_dma: host read DMA engine for the matmul AFU.
// Fetches a contiguous block of 64-byte lines from host memory over an
// Avalon-MM requestor. It uses naturally aligned bursts of 1, 2 or 4 lines.
// Returned lines are buffered in a credit-protected FIFO with a registered
// output and delivered on a valid/ready stream.
// Optional feature: define MU_RD_DMA_PERF_EN to add the perf_cycles and
// perf_stall performance counters.
module mu_host_read_dma #(
    parameter int DATA_W     = 512,
    parameter int ADDR_W     = 48,
    parameter int BURST_W    = 3,
    parameter int FIFO_DEPTH = 64,
    parameter int LEN_W      = 20
) (
    input  logic                primary_clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [LEN_W-1:0]    num_lines,
    output logic                busy,
    output logic                done,
    input  logic                host_read_waitrequest,
    input  logic [DATA_W-1:0]   host_read_readdata,
    input  logic                host_read_readdatavalid,
    output logic [BURST_W-1:0]  host_read_burstcount,
    output logic [ADDR_W-1:0]   host_read_address,
    output logic                host_read_read,
    output logic [DATA_W/8-1:0] host_read_byteenable,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready
`ifdef MU_RD_DMA_PERF_EN
    ,
    output logic [31:0]         perf_cycles,
    output logic [31:0]         perf_stall
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 2;

    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [LEN_W-1:0]    req_left_q, req_left_d;
    logic [LEN_W-1:0]    rx_left_q, rx_left_d;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic [CNT_W-1:0]    mem_count_q, mem_count_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                rd_q, rd_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [BURST_W-1:0]  rd_burst_q, rd_burst_d;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];

    logic                beat_in, out_pop, out_free, mem_pop, bypass, push;
    logic                accept, credit_ok;
    logic [CNT_W-1:0]    fifo_count_q, fifo_count_d;
    logic [BURST_W-1:0]  l_next;
    logic                src_addr_unused;

    // The low six address bits select a byte within a line and are dropped.
    assign src_addr_unused = ^src_addr[5:0];

    // Largest burst in {4,2,1} that fits the remaining count and keeps the
    // line index naturally aligned; 0 when nothing is left.
    function automatic logic [BURST_W-1:0] burst_len(input logic [ADDR_W-1:0] addr,
                                                     input logic [LEN_W-1:0]  left);
        if (left >= LEN_W'(4) && addr[7:6] == 2'b00) return BURST_W'(4);
        else if (left >= LEN_W'(2) && addr[6] == 1'b0) return BURST_W'(2);
        else if (left != '0) return BURST_W'(1);
        else return '0;
    endfunction

    // Response path: bypass straight into the output register when the FIFO
    // is empty, otherwise queue the beat and refill the output from memory.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        beat_in  = host_read_readdatavalid && (state_q == ST_REQ || state_q == ST_WAIT)
                   && (rx_left_q != '0);
        out_pop  = out_valid_q && out_ready;
        out_free = !out_valid_q || out_ready;
        mem_pop  = out_free && (mem_count_q != '0);
        bypass   = out_free && (mem_count_q == '0) && beat_in;
        push     = beat_in && !bypass;
        if (mem_pop) begin
            out_valid_d = 1'b1;
            out_data_d  = mem[rd_ptr_q];
        end else if (bypass) begin
            out_valid_d = 1'b1;
            out_data_d  = host_read_readdata;
        end else if (out_pop) begin
            out_valid_d = 1'b0;
        end
        mem_count_d  = mem_count_q + CNT_W'(push) - CNT_W'(mem_pop);
        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(mem_pop);
        fifo_count_q = mem_count_q + CNT_W'(out_valid_q);
        fifo_count_d = mem_count_d + CNT_W'(out_valid_d);
    end

    // Command control: address/count bookkeeping and state transitions.
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        req_left_d = req_left_q;
        rx_left_d  = rx_left_q;
        inflight_d = inflight_q;
        accept     = rd_q && !host_read_waitrequest;
        if (accept) begin
            req_addr_d = req_addr_q + (ADDR_W'(rd_burst_q) << 6);
            req_left_d = req_left_q - LEN_W'(rd_burst_q);
            inflight_d = inflight_d + CNT_W'(rd_burst_q);
        end
        if (beat_in) begin
            rx_left_d  = rx_left_q - LEN_W'(1);
            inflight_d = inflight_d - CNT_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    req_addr_d = {src_addr[ADDR_W-1:6], 6'b0};
                    req_left_d = num_lines;
                    rx_left_d  = num_lines;
                    // An empty command drains through WAIT for one cycle so
                    // that done lands two cycles after start.
                    state_d    = (num_lines != '0) ? ST_REQ : ST_WAIT;
                end
            end
            ST_REQ: begin
                if (accept && req_left_d == '0) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Looks at next-cycle values so done follows the final
                // handshake by exactly one cycle.
                if (rx_left_d == '0 && fifo_count_d == '0) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next request: hold while stalled, otherwise present the next aligned
    // burst if the FIFO can absorb it on top of everything already owed.
    always_comb begin
        l_next    = burst_len(req_addr_d, req_left_d);
        credit_ok = (SUM_W'(inflight_d) + SUM_W'(fifo_count_d) + SUM_W'(l_next))
                    <= SUM_W'(FIFO_DEPTH);
        rd_d       = rd_q;
        rd_addr_d  = rd_addr_q;
        rd_burst_d = rd_burst_q;
        if (!(rd_q && host_read_waitrequest)) begin
            rd_d       = (state_d == ST_REQ) && (l_next != '0) && credit_ok;
            rd_addr_d  = req_addr_d;
            rd_burst_d = l_next;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge primary_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            req_addr_q  <= '0;
            req_left_q  <= '0;
            rx_left_q   <= '0;
            inflight_q  <= '0;
            mem_count_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rd_q        <= 1'b0;
            rd_addr_q   <= '0;
            rd_burst_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_left_q  <= req_left_d;
            rx_left_q   <= rx_left_d;
            inflight_q  <= inflight_d;
            mem_count_q <= mem_count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rd_q        <= rd_d;
            rd_addr_q   <= rd_addr_d;
            rd_burst_q  <= rd_burst_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge primary_clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers and
        // count define which entries are meaningful, and leaving it unreset
        // lets it map onto RAM.
        if (push) mem[wr_ptr_q] <= host_read_readdata;
    end

    // The credit check makes a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge primary_clk) disable iff (!reset_n)
        !(beat_in && fifo_count_q == CNT_W'(FIFO_DEPTH)));

`ifdef MU_RD_DMA_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Saturating busy-cycle and request-stall counters, cleared on start.
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stall_d  = perf_stall_q;
        if (state_q == ST_IDLE && start) begin
            perf_cycles_d = '0;
            perf_stall_d  = '0;
        end else begin
            if (state_q != ST_IDLE && perf_cycles_q != '1) perf_cycles_d = perf_cycles_q + 32'd1;
            if (state_q == ST_REQ && !accept && perf_stall_q != '1) perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge primary_clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`endif

    assign busy                 = (state_q != ST_IDLE);
    assign done                 = (state_q == ST_DONE);
    assign host_read_read       = rd_q;
    assign host_read_address    = rd_addr_q;
    assign host_read_burstcount = rd_burst_q;
    assign host_read_byteenable = '1;
    assign out_valid            = out_valid_q;
    assign out_data             = out_data_q;

endmodule
